// File: rtl/lz77_job_scheduler.sv
// Round-robin scheduler sharing one LZ77 encoder core between two block sources.
// Optional RUN-phase watchdog enabled by defining LZ77_SCHED_TIMEOUT_EN.
module lz77_job_scheduler #(
    parameter int BLK_LEN = 2048,
    parameter int CNT_W   = 12,
    parameter int TIMEOUT = 65535
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    output logic [1:0]       grant,
    input  logic [15:0]      src_data,
    input  logic [1:0]       src_valid,
    output logic [1:0]       src_ready,
    output logic             enc_reset,
    output logic [7:0]       enc_chardata,
    input  logic             enc_valid,
    input  logic             enc_finish,
    input  logic [3:0]       enc_offset,
    input  logic [2:0]       enc_match_len,
    input  logic [7:0]       enc_char_nxt,
    output logic             tok_valid,
    output logic             tok_id,
    output logic [3:0]       tok_offset,
    output logic [2:0]       tok_match_len,
    output logic [7:0]       tok_char_nxt,
    output logic [1:0]       done,
    output logic [CNT_W-1:0] tok_count,
    output logic             err_underrun,
    output logic             err_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(BLK_LEN - 1);

    state_t           state_reg, state_next;
    logic             owner_reg, owner_next;
    logic             rr_ptr_reg, rr_ptr_next;
    logic             rst_cnt_reg;
    logic [CNT_W-1:0] load_cnt_reg;
    logic [1:0]       grant_reg;
    logic [1:0]       done_reg;
    logic             enc_reset_reg;
    logic             tok_valid_reg;
    logic             tok_id_reg;
    logic [3:0]       tok_offset_reg;
    logic [2:0]       tok_match_len_reg;
    logic [7:0]       tok_char_nxt_reg;
    logic [CNT_W-1:0] tok_count_reg;
    logic             err_underrun_reg;
    logic             timeout_hit;
    logic             load_active;
    logic             job_start;
    logic [7:0]       src_char [2];

    assign load_active = (state_reg == S_LOAD);
    assign job_start   = (state_reg == S_IDLE) && (state_next == S_RST);

    // Per-source char lanes and ready strobes.
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        assign src_char[gi]  = src_data[gi*8 +: 8];
        assign src_ready[gi] = load_active && (owner_reg == 1'(gi));
    end

    // The core cannot stall, so a missing char is replaced by zero.
    assign enc_chardata = (load_active && src_valid[owner_reg]) ? src_char[owner_reg] : 8'h00;

    always_comb begin
        state_next  = state_reg;
        owner_next  = owner_reg;
        rr_ptr_next = rr_ptr_reg;
        case (state_reg)
            S_IDLE: begin
                if (|req) begin
                    owner_next = req[rr_ptr_reg] ? rr_ptr_reg : ~rr_ptr_reg;
                    state_next = S_RST;
                end
            end
            S_RST: begin
                if (rst_cnt_reg) state_next = S_LOAD;
            end
            S_LOAD: begin
                if (load_cnt_reg == LOAD_LAST) state_next = S_RUN;
            end
            S_RUN: begin
                if (enc_finish || timeout_hit) state_next = S_DONE;
            end
            S_DONE: begin
                rr_ptr_next = ~owner_reg;
                state_next  = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= S_IDLE;
            owner_reg     <= 1'b0;
            rr_ptr_reg    <= 1'b0;
            rst_cnt_reg   <= 1'b0;
            load_cnt_reg  <= '0;
            grant_reg     <= 2'b00;
            done_reg      <= 2'b00;
            enc_reset_reg <= 1'b1;
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            rr_ptr_reg    <= rr_ptr_next;
            rst_cnt_reg   <= (state_reg == S_RST) ? ~rst_cnt_reg : 1'b0;
            load_cnt_reg  <= load_active ? (load_cnt_reg + CNT_W'(1)) : '0;
            grant_reg     <= (state_next == S_RST || state_next == S_LOAD || state_next == S_RUN)
                             ? (2'b01 << owner_next) : 2'b00;
            done_reg      <= (state_next == S_DONE) ? (2'b01 << owner_reg) : 2'b00;
            enc_reset_reg <= !(state_next == S_LOAD || state_next == S_RUN);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tok_valid_reg     <= 1'b0;
            tok_id_reg        <= 1'b0;
            tok_offset_reg    <= 4'h0;
            tok_match_len_reg <= 3'h0;
            tok_char_nxt_reg  <= 8'h00;
            tok_count_reg     <= '0;
            err_underrun_reg  <= 1'b0;
        end else begin
            tok_valid_reg <= (state_reg == S_RUN) && enc_valid;
            if (state_reg == S_RUN && enc_valid) begin
                tok_id_reg        <= owner_reg;
                tok_offset_reg    <= enc_offset;
                tok_match_len_reg <= enc_match_len;
                tok_char_nxt_reg  <= enc_char_nxt;
                if (tok_count_reg != '1) tok_count_reg <= tok_count_reg + CNT_W'(1);
            end
            if (job_start) begin
                tok_count_reg    <= '0;
                err_underrun_reg <= 1'b0;
            end else if (load_active && !src_valid[owner_reg]) begin
                err_underrun_reg <= 1'b1;
            end
        end
    end

`ifdef LZ77_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] wd_cnt_reg;
    logic            err_timeout_reg;

    // Counts idle RUN cycles; restarts on every token and on RUN entry.
    assign timeout_hit = (state_reg == S_RUN) && !enc_valid && (wd_cnt_reg == WD_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt_reg      <= '0;
            err_timeout_reg <= 1'b0;
        end else begin
            if (state_reg != S_RUN || enc_valid) wd_cnt_reg <= '0;
            else                                 wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
            if (job_start)        err_timeout_reg <= 1'b0;
            else if (timeout_hit) err_timeout_reg <= 1'b1;
        end
    end

    assign err_timeout = err_timeout_reg;
`else
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT == 0);
    assign timeout_hit    = 1'b0;
    assign err_timeout    = 1'b0;
`endif

    assign grant         = grant_reg;
    assign done          = done_reg;
    assign enc_reset     = enc_reset_reg;
    assign tok_valid     = tok_valid_reg;
    assign tok_id        = tok_id_reg;
    assign tok_offset    = tok_offset_reg;
    assign tok_match_len = tok_match_len_reg;
    assign tok_char_nxt  = tok_char_nxt_reg;
    assign tok_count     = tok_count_reg;
    assign err_underrun  = err_underrun_reg;

endmodule

// File: tb/tb_lz77_job_scheduler.sv
// Directed bench for lz77_job_scheduler: arbitration, load stream, token forwarding,
// underrun, mid-job reset and (with LZ77_SCHED_TIMEOUT_EN) the watchdog.
module tb_lz77_job_scheduler;

    localparam int BLK   = 2048;
    localparam int CNTW  = 12;
`ifdef LZ77_SCHED_TIMEOUT_EN
    localparam int TB_TIMEOUT = 16;
    localparam int LAST_NTOK  = -1;
`else
    localparam int TB_TIMEOUT = 65535;
    localparam int LAST_NTOK  = 3;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [1:0]      req;
    logic [1:0]      grant;
    logic [15:0]     src_data;
    logic [1:0]      src_valid;
    logic [1:0]      src_ready;
    logic            enc_reset;
    logic [7:0]      enc_chardata;
    logic            enc_valid;
    logic            enc_finish;
    logic [3:0]      enc_offset;
    logic [2:0]      enc_match_len;
    logic [7:0]      enc_char_nxt;
    logic            tok_valid;
    logic            tok_id;
    logic [3:0]      tok_offset;
    logic [2:0]      tok_match_len;
    logic [7:0]      tok_char_nxt;
    logic [1:0]      done;
    logic [CNTW-1:0] tok_count;
    logic            err_underrun;
    logic            err_timeout;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    lz77_job_scheduler #(
        .BLK_LEN (BLK),
        .CNT_W   (CNTW),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .grant         (grant),
        .src_data      (src_data),
        .src_valid     (src_valid),
        .src_ready     (src_ready),
        .enc_reset     (enc_reset),
        .enc_chardata  (enc_chardata),
        .enc_valid     (enc_valid),
        .enc_finish    (enc_finish),
        .enc_offset    (enc_offset),
        .enc_match_len (enc_match_len),
        .enc_char_nxt  (enc_char_nxt),
        .tok_valid     (tok_valid),
        .tok_id        (tok_id),
        .tok_offset    (tok_offset),
        .tok_match_len (tok_match_len),
        .tok_char_nxt  (tok_char_nxt),
        .done          (done),
        .tok_count     (tok_count),
        .err_underrun  (err_underrun),
        .err_timeout   (err_timeout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
            $error("check %s did not match", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one job from IDLE (req already driven) back to IDLE.
    // ntok < 0 means the core stays silent and the watchdog must end the job.
    task automatic do_job(input logic [1:0] g, input int bad, input int ntok, input logic drop);
        int       ok_cycles;
        int       n;
        logic     gid;
        logic [7:0] ch;
        logic [7:0] nxt;
        gid = (g == 2'b10);
        ch  = gid ? 8'h52 : 8'h41;
        tick();
        if (drop) req = 2'b00;
        check("rst1_grant", 32'(grant), 32'(g));
        check("rst1_enc_reset", 32'(enc_reset), 32'd1);
        check("rst1_src_ready", 32'(src_ready), 32'd0);
        tick();
        check("rst2_enc_reset", 32'(enc_reset), 32'd1);
        check("rst2_err_underrun", 32'(err_underrun), 32'd0);
        check("rst2_tok_count", 32'(tok_count), 32'd0);
        tick();
        ok_cycles = 0;
        for (int k = 0; k < BLK; k++) begin
            src_valid = (k == bad) ? ~g : 2'b11;
            enc_valid = (k == 5);
            #1;
            if (k == bad) check("underrun_char", 32'(enc_chardata), 32'd0);
            if (src_ready == g && enc_reset == 1'b0 && grant == g && tok_valid == 1'b0 &&
                enc_chardata == ((k == bad) ? 8'h00 : ch))
                ok_cycles++;
            tick();
        end
        src_valid = 2'b11;
        enc_valid = 1'b0;
        check("load_cycles", 32'(ok_cycles), 32'(BLK));
        check("run_src_ready", 32'(src_ready), 32'd0);
        check("run_enc_reset", 32'(enc_reset), 32'd0);
        check("run_err_underrun", 32'(err_underrun), (bad >= 0) ? 32'd1 : 32'd0);
        if (ntok >= 0) begin
            for (int i = 0; i < ntok; i++) begin
                nxt = (i == ntok - 1) ? 8'h24 : 8'(8'h30 + i);
                enc_offset    = i[3:0];
                enc_match_len = i[2:0];
                enc_char_nxt  = nxt;
                enc_valid     = 1'b1;
                tick();
                enc_valid = 1'b0;
                check("tok_valid", 32'(tok_valid), 32'd1);
                check("tok_id", 32'(tok_id), 32'(gid));
                check("tok_offset", 32'(tok_offset), 32'(i[3:0]));
                check("tok_match_len", 32'(tok_match_len), 32'(i[2:0]));
                check("tok_char_nxt", 32'(tok_char_nxt), 32'(nxt));
                check("tok_count_run", 32'(tok_count), 32'(i + 1));
                tick();
                check("tok_valid_gap", 32'(tok_valid), 32'd0);
            end
            check("done_before_finish", 32'(done), 32'd0);
            enc_finish = 1'b1;
            tick();
            enc_finish = 1'b0;
            check("done_pulse", 32'(done), 32'(g));
            check("done_tok_count", 32'(tok_count), 32'(ntok));
            check("done_err_timeout", 32'(err_timeout), 32'd0);
            if (ntok > 0) check("final_char_nxt", 32'(tok_char_nxt), 32'h24);
        end else begin
            n = 0;
            while (done == 2'b00 && n < 100) begin
                tick();
                n++;
            end
            check("timeout_cycles", 32'(n), 32'(TB_TIMEOUT));
            check("timeout_err", 32'(err_timeout), 32'd1);
            check("timeout_done", 32'(done), 32'(g));
        end
        check("done_grant", 32'(grant), 32'd0);
        check("done_enc_reset", 32'(enc_reset), 32'd1);
        tick();
        check("idle_done_clear", 32'(done), 32'd0);
        check("idle_grant", 32'(grant), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        reset         = 1'b0;
        req           = 2'b00;
        src_data      = {8'h52, 8'h41};
        src_valid     = 2'b11;
        enc_valid     = 1'b0;
        enc_finish    = 1'b0;
        enc_offset    = 4'h0;
        enc_match_len = 3'h0;
        enc_char_nxt  = 8'h00;
        tick();
        tick();
        check("reset_grant", 32'(grant), 32'd0);
        check("reset_src_ready", 32'(src_ready), 32'd0);
        check("reset_enc_reset", 32'(enc_reset), 32'd1);
        check("reset_enc_chardata", 32'(enc_chardata), 32'd0);
        check("reset_tok_valid", 32'(tok_valid), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_tok_count", 32'(tok_count), 32'd0);
        check("reset_err", 32'({err_underrun, err_timeout}), 32'd0);
        reset = 1'b1;

        // Single source, request dropped while granted, five tokens.
        req = 2'b01;
        do_job(2'b01, -1, 5, 1'b1);
        $display("job src0 single: done, tok_count=%0d", tok_count);

        // Both requesting from reset: strict alternation.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        req = 2'b11;
        do_job(2'b01, -1, 2, 1'b0);
        $display("job alt 1: grant src0");
        do_job(2'b10, -1, 2, 1'b0);
        $display("job alt 2: grant src1");
        do_job(2'b01, 100, 2, 1'b0);
        $display("job alt 3: grant src0 with underrun at char 100");
        check("underrun_sticky_idle", 32'(err_underrun), 32'd1);
        do_job(2'b10, -1, 1, 1'b0);
        $display("job alt 4: grant src1, underrun cleared");

        // Reset in the middle of LOAD aborts without done, then restarts.
        req = 2'b01;
        tick();
        tick();
        tick();
        tick();
        tick();
        check("midload_ready", 32'(src_ready), 32'b01);
        reset = 1'b0;
        #1;
        check("abort_grant", 32'(grant), 32'd0);
        check("abort_enc_reset", 32'(enc_reset), 32'd1);
        check("abort_src_ready", 32'(src_ready), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        tick();
        check("abort_done_held", 32'(done), 32'd0);
        reset = 1'b1;
        do_job(2'b01, -1, LAST_NTOK, 1'b0);
        $display("job restart after abort: done");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
